inv_addkey_mixcol: RTL and testbench



---
 rtl/aes_pkg.sv | 54 +++++
 rtl/inv_addkey_mixcol_if.sv | 33 +++
 rtl/inv_mix_column.sv | 26 ++
 rtl/inv_addkey_mixcol.sv | 93 +++++++++
 tb/tb_inv_addkey_mixcol.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES decryption constants, the round-tail FSM state type and the
//   GF(2^8) helpers (polynomial 0x11b) used by InvMixColumns.
//   No ports; imported by the round-tail interface and modules.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_NB      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_addkey_mixcol_if.sv
// ---------------------------------------------------------------------------
// inv_addkey_mixcol_if
//   Handshake bundle of the decryption round tail.
//   Upstream : in_valid, in_ready, state_in, round_key, last_round
//   Downstream: out_valid, out_ready, state_out
//   Status   : busy
//   Byte b of any state/key vector is bits [8b +: 8] (byte 0 leftmost).
//   slave  = round-tail block, master = the surrounding datapath/bench.
// ---------------------------------------------------------------------------
interface inv_addkey_mixcol_if;
    import aes_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [0:AES_STATE_W-1]   state_in;
    logic [0:AES_STATE_W-1]   round_key;
    logic                     last_round;
    logic                     out_valid;
    logic                     out_ready;
    logic [0:AES_STATE_W-1]   state_out;
    logic                     busy;

    modport slave (
        input  in_valid, state_in, round_key, last_round, out_ready,
        output in_ready, out_valid, state_out, busy
    );

    modport master (
        output in_valid, state_in, round_key, last_round, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

endinterface

// File: rtl/inv_mix_column.sv
// ---------------------------------------------------------------------------
// inv_mix_column
//   Combinational InvMixColumns of one 32-bit column.
//   col_i : column in, row 0 in bits [31:24]
//   col_o : column out, same layout
// ---------------------------------------------------------------------------
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign col_o[31:24] = gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3);
    assign col_o[23:16] = gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3) ^ gf_mul_09(a0);
    assign col_o[15:8]  = gf_mul_0e(a2) ^ gf_mul_0b(a3) ^ gf_mul_0d(a0) ^ gf_mul_09(a1);
    assign col_o[7:0]   = gf_mul_0e(a3) ^ gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2);

endmodule

// File: rtl/inv_addkey_mixcol.sv
// ---------------------------------------------------------------------------
// inv_addkey_mixcol
//   Decryption round tail: AddRoundKey on accept, then column-serial
//   InvMixColumns (COLS_PER_CYCLE columns per CALC cycle). last_round
//   skips InvMixColumns.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of inv_addkey_mixcol_if (valid/ready in and out,
//             state/key/last_round in, state_out, busy)
// ---------------------------------------------------------------------------
module inv_addkey_mixcol
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    inv_addkey_mixcol_if.slave   bus
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("inv_addkey_mixcol: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Column index of the first group in the final CALC cycle.
    localparam logic [1:0] LAST_COL = 2'(AES_NB - COLS_PER_CYCLE);

    state_e                  state_q, state_d;
    logic [1:0]              col_q, col_d;
    logic [0:AES_STATE_W-1]  work_q, work_d;

    logic [1:0]              col_idx [COLS_PER_CYCLE];
    logic [31:0]             mix_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        assign col_idx[g] = col_q + 2'(g);
        inv_mix_column u_mix (
            .col_i (work_q[{col_idx[g], 5'd0} +: 32]),
            .col_o (mix_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.state_in ^ bus.round_key;
                    col_d   = '0;
                    state_d = bus.last_round ? DONE : CALC;
                end
            end
            CALC: begin
                for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
                    work_d[{col_idx[i], 5'd0} +: 32] = mix_out[i];
                end
                // 2-bit counter wraps to 0 after the last group.
                col_d = col_q + 2'(COLS_PER_CYCLE);
                if (col_q == LAST_COL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_out = work_q;

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
// ---------------------------------------------------------------------------
// tb_inv_addkey_mixcol
//   Drives three instances (COLS_PER_CYCLE = 1, 2, 4) with the same stimulus
//   and checks each against hand-computed results and its own latency.
// ---------------------------------------------------------------------------
module tb_inv_addkey_mixcol;

    typedef struct {
        logic [0:127] s;
        logic [0:127] k;
        logic         last;
        logic [0:127] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic         in_valid, last_round, out_ready;
    logic [0:127] state_in, round_key;

    inv_addkey_mixcol_if b1 ();
    inv_addkey_mixcol_if b2 ();
    inv_addkey_mixcol_if b4 ();

    assign b1.in_valid = in_valid;   assign b2.in_valid = in_valid;   assign b4.in_valid = in_valid;
    assign b1.state_in = state_in;   assign b2.state_in = state_in;   assign b4.state_in = state_in;
    assign b1.round_key = round_key; assign b2.round_key = round_key; assign b4.round_key = round_key;
    assign b1.last_round = last_round; assign b2.last_round = last_round; assign b4.last_round = last_round;
    assign b1.out_ready = out_ready; assign b2.out_ready = out_ready; assign b4.out_ready = out_ready;

    logic         ov [3];
    logic         ir [3];
    logic         bs [3];
    logic [0:127] so [3];

    assign ov[0] = b1.out_valid; assign ov[1] = b2.out_valid; assign ov[2] = b4.out_valid;
    assign ir[0] = b1.in_ready;  assign ir[1] = b2.in_ready;  assign ir[2] = b4.in_ready;
    assign bs[0] = b1.busy;      assign bs[1] = b2.busy;      assign bs[2] = b4.busy;
    assign so[0] = b1.state_out; assign so[1] = b2.state_out; assign so[2] = b4.state_out;

    inv_addkey_mixcol #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    inv_addkey_mixcol #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
    inv_addkey_mixcol #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    int errors = 0;
    int checks = 0;
    int ncyc [3] = '{4, 2, 1};
    vec_t vt [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s in_ready c%0d", tag, 1 << d), 128'(ir[d]), 128'd1);
            chk($sformatf("%s out_valid c%0d", tag, 1 << d), 128'(ov[d]), 128'd0);
            chk($sformatf("%s busy c%0d", tag, 1 << d), 128'(bs[d]), 128'd0);
        end
    endtask

    // Accept one vector (accept edge counts as cycle 1), watch up to 12 edges
    // for out_valid, then check latency and data. Leaves DUTs in DONE.
    task automatic run_vec(input vec_t v, input string tag);
        int           lat [3];
        logic [0:127] got [3];
        int           exp_lat;
        for (int d = 0; d < 3; d++) begin
            lat[d] = 0;
            got[d] = '0;
        end
        @(negedge clk);
        state_in   = v.s;
        round_key  = v.k;
        last_round = v.last;
        in_valid   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) in_valid = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (ov[d] === 1'b1 && lat[d] == 0) begin
                    lat[d] = k;
                    got[d] = so[d];
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            exp_lat = v.last ? 1 : ncyc[d] + 1;
            chk($sformatf("%s latency c%0d", tag, 1 << d), 128'(lat[d]), 128'(exp_lat));
            chk($sformatf("%s data c%0d", tag, 1 << d), got[d], v.exp);
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_idle(tag);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [0:127] key4;
        logic         stable [3];

        key4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        vt[0] = '{s: 128'h8e4da1bc_01010101_01010101_01010101, k: '0, last: 1'b0,
                  exp: 128'hdb135345_01010101_01010101_01010101};
        vt[1] = '{s: 128'h9fdc589d_d5d5d7d6_4d7ebdf8_c6c6c6c6, k: '0, last: 1'b0,
                  exp: 128'hf20a225c_d4d4d4d5_2d26314c_c6c6c6c6};
        vt[2] = '{s: 128'h00112233445566778899aabbccddeeff,
                  k: 128'h000102030405060708090a0b0c0d0e0f, last: 1'b1,
                  exp: 128'h00102030405060708090a0b0c0d0e0f0};
        vt[3] = '{s: 128'h8e4da1bc_01010101_01010101_01010101 ^ key4, k: key4, last: 1'b0,
                  exp: 128'hdb135345_01010101_01010101_01010101};

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        last_round = 1'b0;
        state_in   = '0;
        round_key  = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset state_out c%0d", 1 << d), so[d], 128'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
            release_out($sformatf("vec%0d release", i));
        end

        // Backpressure: hold out_ready low 10 cycles with junk in_valid pulses
        run_vec(vt[1], "stall");
        for (int d = 0; d < 3; d++) stable[d] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0];
            state_in = {4{$urandom}};
            round_key = {4{$urandom}};
            last_round = c[1];
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++)
                if (ov[d] !== 1'b1 || so[d] !== vt[1].exp || ir[d] !== 1'b0) stable[d] = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("stall stable c%0d", 1 << d), 128'(stable[d]), 128'd1);
            chk($sformatf("stall busy c%0d", 1 << d), 128'(bs[d]), 128'd1);
            chk($sformatf("stall data c%0d", 1 << d), so[d], vt[1].exp);
        end
        release_out("stall release");

        // Asynchronous reset during CALC
        @(negedge clk);
        state_in   = vt[1].s;
        round_key  = vt[1].k;
        last_round = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset busy-before c1", 128'(bs[0]), 128'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_idle("midreset");
        for (int d = 0; d < 3; d++)
            chk($sformatf("midreset state_out c%0d", 1 << d), so[d], 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(vt[0], "post-reset");
        release_out("post-reset release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
